ntt_f2h_dma: RTL and testbench

//  Single-channel DMA between the HPS SDRAM (FPGA-to-HPS sdram0 Avalon-MM port, 64-bit, word-addressed)
//  and the NTT datapath. Programmed from the slave_template control registers (dataout_*), reports to datain_*.

---
 rtl/ntt_dma_pkg.sv | 26 ++
 rtl/ntt_dma_fifo.sv | 63 ++++++
 rtl/ntt_f2h_dma.sv | 182 ++++++++++++++++++
 tb/tb_ntt_f2h_dma.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_dma_pkg.sv
// ============================================================================
// Module  : ntt_dma_pkg
// Purpose : Shared types and constants for the NTT FPGA-to-HPS DMA.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ntt_dma_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 64;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DRAIN = 3'd2,
    WR       = 3'd3,
    DONE     = 3'd4
  } dma_state_e;

endpackage

`default_nettype wire

// File: rtl/ntt_dma_fifo.sv
// ============================================================================
// Module  : ntt_dma_fifo
// Purpose : Synchronous show-ahead FIFO buffering SDRAM read returns.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_dma_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   used,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_used;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_used <= r_used + (PTR_W+1)'(1);
        2'b01:   r_used <= r_used - (PTR_W+1)'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign used  = r_used;
  assign empty = (r_used == '0);
  assign full  = (r_used == (PTR_W+1)'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/ntt_f2h_dma.sv
// ============================================================================
// Module  : ntt_f2h_dma
// Purpose : Single-channel DMA between HPS SDRAM (Avalon-MM) and NTT streams.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_f2h_dma #(
  parameter int ADDR_W     = ntt_dma_pkg::ADDR_W,
  parameter int DATA_W     = ntt_dma_pkg::DATA_W,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              ctrl_start,
  input  logic              ctrl_dir,
  input  logic [ADDR_W-1:0] ctrl_base_addr,
  input  logic [LEN_W-1:0]  ctrl_len,
  output logic              stat_busy,
  output logic              stat_done,
  output logic [LEN_W-1:0]  stat_count,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic [7:0]        avm_byteenable,
  output logic              avm_burstcount,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  output logic              snk_ready
);

  import ntt_dma_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  dma_state_e        r_state;
  dma_state_e        w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_issued;
  logic [LEN_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_done;
  logic              r_wr_valid;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_start_ok;
  logic              w_in_read;
  logic              w_credit_ok;
  logic [CNT_W:0]    w_credit_used;
  logic              w_rd_cmd;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_rdv;
  logic              w_pop;
  logic              w_take;
  logic [DATA_W-1:0] w_fifo_head;
  logic [CNT_W-1:0]  w_fifo_used;
  logic              w_fifo_empty;
  logic              w_fifo_full;

  assign w_start_ok = ctrl_start && (r_state == IDLE);
  assign w_in_read  = (r_state == RD_ISSUE) || (r_state == RD_DRAIN);

  // Every read reserves a FIFO slot, so returns can never overflow the buffer.
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_used};
  assign w_credit_ok   = w_credit_used < (CNT_W+1)'(FIFO_DEPTH);

  // Credit only shrinks while stalled, so this command stays stable under waitrequest.
  assign w_rd_cmd = (r_state == RD_ISSUE) && (r_issued != r_len) && w_credit_ok;
  assign w_rd_acc = w_rd_cmd && !avm_waitrequest;
  assign w_wr_acc = r_wr_valid && !avm_waitrequest;
  assign w_rdv    = avm_readdatavalid && (r_outstanding != '0);

  assign src_valid = w_in_read && !w_fifo_empty;
  assign src_data  = src_valid ? w_fifo_head : '0;
  assign w_pop     = src_valid && src_ready;

  assign snk_ready = (r_state == WR) && (r_issued != r_len) && (!r_wr_valid || !avm_waitrequest);
  assign w_take    = snk_valid && snk_ready;

  ntt_dma_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .push      (w_rdv),
    .push_data (avm_readdata),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .used      (w_fifo_used),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= IDLE;
    else                r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          if (ctrl_len == '0)            w_state_next = DONE;
          else if (ctrl_dir == DIR_READ)  w_state_next = RD_ISSUE;
          else if (ctrl_dir == DIR_WRITE) w_state_next = WR;
        end
      end
      RD_ISSUE: if (w_rd_acc && (r_issued == r_len - LEN_W'(1))) w_state_next = RD_DRAIN;
      RD_DRAIN: if (w_pop && (r_count == r_len - LEN_W'(1)))     w_state_next = DONE;
      WR:       if (w_wr_acc && (r_count == r_len - LEN_W'(1)))  w_state_next = DONE;
      DONE:     w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_addr        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
      r_wr_valid    <= 1'b0;
      r_wr_data     <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr   <= ctrl_base_addr;
        r_len    <= ctrl_len;
        r_issued <= '0;
        r_count  <= '0;
        r_done   <= 1'b0;
      end else begin
        if (w_rd_acc || w_wr_acc) r_addr   <= r_addr + ADDR_W'(1);
        if (w_rd_acc || w_take)   r_issued <= r_issued + LEN_W'(1);
        if (w_pop || w_wr_acc)    r_count  <= r_count + LEN_W'(1);
        if (r_state == DONE)      r_done   <= 1'b1;
      end

      if (w_rd_acc && !w_rdv)      r_outstanding <= r_outstanding + CNT_W'(1);
      else if (!w_rd_acc && w_rdv) r_outstanding <= r_outstanding - CNT_W'(1);

      if (w_take) begin
        r_wr_valid <= 1'b1;
        r_wr_data  <= snk_data;
      end else if (w_wr_acc) begin
        r_wr_valid <= 1'b0;
      end
    end
  end

  assign stat_busy      = (r_state == RD_ISSUE) || (r_state == RD_DRAIN) || (r_state == WR);
  assign stat_done      = r_done || (r_state == DONE);
  assign stat_count     = r_count;
  assign avm_address    = r_addr;
  assign avm_read       = w_rd_cmd;
  assign avm_write      = r_wr_valid;
  assign avm_writedata  = r_wr_data;
  assign avm_byteenable = 8'hFF;
  assign avm_burstcount = 1'b1;

  // A return with nothing outstanding is a stray from before a reset and is dropped.
  a_rdv_expected: assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
                                   avm_readdatavalid |-> (r_outstanding != '0));
  a_no_overflow:  assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
                                   !(w_rdv && w_fifo_full));

endmodule

`default_nettype wire

// File: tb/tb_ntt_f2h_dma.sv
// ============================================================================
// Module  : tb_ntt_f2h_dma
// Purpose : Scoreboard bench for ntt_f2h_dma with an Avalon slave model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ntt_f2h_dma;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        ctrl_start, ctrl_dir;
  logic [25:0] ctrl_base_addr;
  logic [15:0] ctrl_len;
  logic        stat_busy, stat_done;
  logic [15:0] stat_count;
  logic [25:0] avm_address;
  logic        avm_read, avm_write;
  logic [63:0] avm_writedata;
  logic [7:0]  avm_byteenable;
  logic        avm_burstcount;
  logic [63:0] avm_readdata;
  logic        avm_readdatavalid, avm_waitrequest;
  logic [63:0] src_data;
  logic        src_valid, src_ready;
  logic [63:0] snk_data;
  logic        snk_valid, snk_ready;

  always #5 clk_clk = ~clk_clk;

  ntt_f2h_dma dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .ctrl_start(ctrl_start), .ctrl_dir(ctrl_dir), .ctrl_base_addr(ctrl_base_addr), .ctrl_len(ctrl_len),
    .stat_busy(stat_busy), .stat_done(stat_done), .stat_count(stat_count),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready)
  );

  typedef struct { int due; logic [63:0] data; } ret_t;
  typedef struct { logic [25:0] addr; logic [63:0] data; } wr_t;

  int          checks = 0, failures = 0;
  int          cyc = 0;
  int          wait_pct = 0, ready_pct = 100;
  ret_t        ret_q[$];
  logic [63:0] src_exp_q[$];
  wr_t         wr_exp_q[$];
  logic [63:0] snk_words[64];
  int          snk_idx = 0, snk_n = 0;
  logic [25:0] exp_rd_addr = '0;
  int          rd_issued = 0, cmd_seen = 0, pops = 0;
  int          first_rdv_cyc = -1, first_src_cyc = -1;

  // Memory contents as seen by the slave: a fixed function of the word address.
  function automatic logic [63:0] rd_word(logic [25:0] a);
    return {a ^ 26'h2AA_AAAA, 12'hC3D, a};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Avalon slave (fixed 3-cycle read latency, random stalls) and stream drivers.
  initial begin
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = '0;
    src_ready = 0; snk_valid = 0; snk_data = '0;
    forever begin
      @(negedge clk_clk);
      avm_readdatavalid = 1'b0;
      if (!reset_reset_n) ret_q.delete();
      else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        ret_t r;
        r = ret_q.pop_front();
        avm_readdatavalid = 1'b1;
        avm_readdata = r.data;
        if (first_rdv_cyc < 0) first_rdv_cyc = cyc;
      end
      avm_waitrequest = ($urandom_range(99) < wait_pct);
      src_ready = ($urandom_range(99) < ready_pct);
      snk_valid = (snk_idx < snk_n);
      snk_data = snk_valid ? snk_words[snk_idx] : '0;
      #1;
      if (reset_reset_n && avm_read && !avm_waitrequest)
        ret_q.push_back('{due: cyc + 3, data: rd_word(avm_address)});
      if (snk_valid && snk_ready) snk_idx++;
    end
  end

  // Monitor: pops expected values whenever the DUT completes a transfer.
  initial begin
    forever begin
      @(negedge clk_clk);
      #2;
      if (reset_reset_n) begin
        if (avm_read || avm_write) cmd_seen++;
        if (avm_read && !avm_waitrequest) begin
          rd_issued++;
          check("rd_addr", 64'(avm_address), 64'(exp_rd_addr));
          exp_rd_addr = exp_rd_addr + 26'd1;
        end
        if (avm_write && !avm_waitrequest) begin
          if (wr_exp_q.size() == 0) check("wr_unexpected", 64'(avm_address), 64'h0);
          else begin
            wr_t w;
            w = wr_exp_q.pop_front();
            check("wr_addr", 64'(avm_address), 64'(w.addr));
            check("wr_data", avm_writedata, w.data);
          end
        end
        if (src_valid && first_src_cyc < 0) first_src_cyc = cyc;
        if (src_valid && src_ready) begin
          pops++;
          if (src_exp_q.size() == 0) check("src_unexpected", src_data, 64'h0);
          else check("src_data", src_data, src_exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_xfer(logic dir, logic [25:0] base, logic [15:0] len);
    @(negedge clk_clk);
    ctrl_dir = dir; ctrl_base_addr = base; ctrl_len = len; ctrl_start = 1'b1;
    @(negedge clk_clk);
    ctrl_start = 1'b0;
    #3;
  endtask

  task automatic wait_done(string name, int budget);
    int n = 0;
    while (!stat_done && n < budget) begin
      @(negedge clk_clk);
      #3;
      n++;
    end
    check({name, "_done"}, 64'(stat_done), 64'h1);
    check({name, "_busy_low"}, 64'(stat_busy), 64'h0);
  endtask

  task automatic check_reset_outputs(string p);
    check({p, "_busy"}, 64'(stat_busy), 64'h0);
    check({p, "_done"}, 64'(stat_done), 64'h0);
    check({p, "_count"}, 64'(stat_count), 64'h0);
    check({p, "_addr"}, 64'(avm_address), 64'h0);
    check({p, "_rdwr"}, 64'({avm_read, avm_write}), 64'h0);
    check({p, "_wdata"}, avm_writedata, 64'h0);
    check({p, "_be_bc"}, 64'({avm_byteenable, avm_burstcount}), 64'h1FF);
    check({p, "_src"}, 64'({src_valid, snk_ready}), 64'h0);
    check({p, "_src_data"}, src_data, 64'h0);
  endtask

  task automatic plan_read(logic [25:0] base, int len);
    exp_rd_addr = base;
    rd_issued = 0; pops = 0; cmd_seen = 0;
    for (int i = 0; i < len; i++) src_exp_q.push_back(rd_word(base + 26'(i)));
  endtask

  initial begin
    int n;
    ctrl_start = 0; ctrl_dir = 0; ctrl_base_addr = '0; ctrl_len = '0;
    repeat (3) @(negedge clk_clk);
    #3;
    check_reset_outputs("rst");
    reset_reset_n = 1'b1;

    // 1: basic read, no stalls
    wait_pct = 0; ready_pct = 100; first_rdv_cyc = -1; first_src_cyc = -1;
    plan_read(26'h100, 8);
    start_xfer(1'b0, 26'h100, 16'd8);
    check("t1_busy", 64'(stat_busy), 64'h1);
    wait_done("t1", 200);
    check("t1_count", 64'(stat_count), 64'd8);
    check("t1_reads", 64'(rd_issued), 64'd8);
    check("t1_src_left", 64'(src_exp_q.size()), 64'd0);
    check("t1_latency", 64'(first_src_cyc - first_rdv_cyc), 64'd1);

    // 2: read with back-pressure, credit must cap issued reads at the FIFO depth
    plan_read(26'h2000, 64);
    ready_pct = 0;
    start_xfer(1'b0, 26'h2000, 16'd64);
    repeat (200) @(negedge clk_clk);
    #3;
    check("t2_reads_capped", 64'(rd_issued), 64'd16);
    check("t2_count_stalled", 64'(stat_count), 64'd0);
    check("t2_src_valid", 64'(src_valid), 64'h1);
    ready_pct = 70; wait_pct = 30;
    wait_done("t2", 2000);
    check("t2_count", 64'(stat_count), 64'd64);
    check("t2_src_left", 64'(src_exp_q.size()), 64'd0);

    // 3: write across the top of the address space with random stalls
    wait_pct = 50;
    for (int i = 0; i < 4; i++) begin
      snk_words[i] = {$urandom, $urandom};
      wr_exp_q.push_back('{addr: 26'h3FFFFFE + 26'(i), data: snk_words[i]});
    end
    snk_idx = 0; snk_n = 4;
    start_xfer(1'b1, 26'h3FFFFFE, 16'd4);
    wait_done("t3", 300);
    check("t3_count", 64'(stat_count), 64'd4);
    check("t3_wr_left", 64'(wr_exp_q.size()), 64'd0);
    check("t3_snk_taken", 64'(snk_idx), 64'd4);
    snk_n = 0; snk_idx = 0;

    // 4: zero-length transfer
    cmd_seen = 0; wait_pct = 0;
    start_xfer(1'b0, 26'h55, 16'd0);
    @(negedge clk_clk);
    #3;
    check("t4_done", 64'(stat_done), 64'h1);
    check("t4_count", 64'(stat_count), 64'd0);
    repeat (3) @(negedge clk_clk);
    #3;
    check("t4_no_cmd", 64'(cmd_seen), 64'd0);
    check("t4_done_sticky", 64'(stat_done), 64'h1);

    // 5: start while busy is ignored; a later start is accepted
    wait_pct = 20; ready_pct = 100;
    plan_read(26'h40, 16);
    start_xfer(1'b0, 26'h40, 16'd16);
    repeat (4) @(negedge clk_clk);
    start_xfer(1'b1, 26'h999, 16'd3);
    check("t5_still_busy", 64'(stat_busy), 64'h1);
    wait_done("t5", 400);
    check("t5_count", 64'(stat_count), 64'd16);
    check("t5_reads", 64'(rd_issued), 64'd16);
    plan_read(26'h500, 2);
    start_xfer(1'b0, 26'h500, 16'd2);
    check("t5b_done_cleared", 64'(stat_done), 64'h0);
    wait_done("t5b", 200);
    check("t5b_count", 64'(stat_count), 64'd2);
    check("t5b_src_left", 64'(src_exp_q.size()), 64'd0);

    // 6: asynchronous reset in the middle of a read
    wait_pct = 0; ready_pct = 100;
    plan_read(26'h700, 16);
    start_xfer(1'b0, 26'h700, 16'd16);
    n = 0;
    while (pops < 5 && n < 200) begin
      @(negedge clk_clk);
      #3;
      n++;
    end
    check("t6_reached_5", 64'(pops >= 5), 64'h1);
    reset_reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    src_exp_q.delete();
    ret_q.delete();
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    plan_read(26'h3FF, 2);
    start_xfer(1'b0, 26'h3FF, 16'd2);
    wait_done("t6b", 200);
    check("t6b_count", 64'(stat_count), 64'd2);
    check("t6b_src_left", 64'(src_exp_q.size()), 64'd0);

    repeat (5) @(negedge clk_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
